// File: rtl/robot_nav_ctrl.sv
`default_nettype none
// ============================================================================
// robot_nav_ctrl : two-wheel 4-wire stepper navigation FSM with a bump-driven
//                  back-up / turn-away manoeuvre. Macro HALF_STEP_EN selects
//                  8-phase half-step coil drive instead of 4-phase full-step.
// Revision       : 1.0
// ============================================================================
module robot_nav_ctrl #(
  parameter int STEP_DIV     = 4,
  parameter int BACKUP_STEPS = 8,
  parameter int TURN_STEPS   = 4,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [1:0] bump,
  output logic [3:0] wheel_wires_left,
  output logic [3:0] wheel_wires_right,
  output logic [1:0] nav_state,
  output logic       busy
);

`ifdef HALF_STEP_EN
  localparam int IDX_W = 3;
`else
  localparam int IDX_W = 2;
`endif
  localparam int CNT_MAX = (BACKUP_STEPS > TURN_STEPS) ? BACKUP_STEPS : TURN_STEPS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int DIV_W   = $clog2(STEP_DIV);
  localparam int SYNC_W  = 2 * SYNC_STAGES;

  localparam logic [DIV_W-1:0] c_DIV_LAST    = DIV_W'(STEP_DIV - 1);
  localparam logic [CNT_W-1:0] c_BACKUP_LAST = CNT_W'(BACKUP_STEPS - 1);
  localparam logic [CNT_W-1:0] c_TURN_LAST   = CNT_W'(TURN_STEPS - 1);
  localparam logic [IDX_W-1:0] c_IDX_ONE     = IDX_W'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_FWD    = 2'b01,
    S_BACKUP = 2'b10,
    S_TURN   = 2'b11
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [IDX_W-1:0]   r_idx_l, r_idx_r, w_idx_l_nxt, w_idx_r_nxt;
  logic               r_turn_left, w_turn_left_nxt;
  logic [SYNC_W-1:0]  r_sync;
  logic [1:0]         r_sync_prev;
  logic [1:0]         w_sync_out, w_edge;
  logic               w_tick;
  logic [3:0]         r_wheel_l, r_wheel_r;
  logic               r_busy;

  function automatic logic [3:0] f_coil(input logic [IDX_W-1:0] idx);
`ifdef HALF_STEP_EN
    case (idx)
      3'd0:    f_coil = 4'b0001;
      3'd1:    f_coil = 4'b0011;
      3'd2:    f_coil = 4'b0010;
      3'd3:    f_coil = 4'b0110;
      3'd4:    f_coil = 4'b0100;
      3'd5:    f_coil = 4'b1100;
      3'd6:    f_coil = 4'b1000;
      default: f_coil = 4'b1001;
    endcase
`else
    f_coil = 4'b0001 << idx;
`endif
  endfunction

  // Both bump bits share one shift register; the oldest pair is the synchronised value.
  assign w_sync_out = r_sync[SYNC_W-1 -: 2];
  assign w_edge     = w_sync_out & ~r_sync_prev;
  assign w_tick     = (r_div == c_DIV_LAST);

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_idx_l_nxt     = r_idx_l;
    w_idx_r_nxt     = r_idx_r;
    w_turn_left_nxt = r_turn_left;
    if (!enable) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_FWD;
        S_FWD: begin
          if (w_tick) begin
            w_idx_l_nxt = r_idx_l + c_IDX_ONE;
            w_idx_r_nxt = r_idx_r - c_IDX_ONE;
          end
          if (w_edge != 2'b00) begin
            w_state_nxt     = S_BACKUP;
            w_turn_left_nxt = ~w_edge[0];
            w_cnt_nxt       = '0;
          end
        end
        S_BACKUP: begin
          if (w_tick) begin
            w_idx_l_nxt = r_idx_l - c_IDX_ONE;
            w_idx_r_nxt = r_idx_r + c_IDX_ONE;
            if (r_cnt == c_BACKUP_LAST) begin
              w_state_nxt = S_TURN;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
        default: begin
          if (w_tick) begin
            w_idx_l_nxt = r_turn_left ? (r_idx_l - c_IDX_ONE) : (r_idx_l + c_IDX_ONE);
            w_idx_r_nxt = r_turn_left ? (r_idx_r - c_IDX_ONE) : (r_idx_r + c_IDX_ONE);
            if (r_cnt == c_TURN_LAST) begin
              w_state_nxt = S_FWD;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
    // Restart the step period on every state change so each state starts with a full period.
    if ((w_state_nxt != r_state) || (w_state_nxt == S_IDLE) || w_tick) begin
      w_div_nxt = '0;
    end else begin
      w_div_nxt = r_div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_cnt       <= '0;
      r_idx_l     <= '0;
      r_idx_r     <= '0;
      r_turn_left <= 1'b0;
      r_sync      <= '0;
      r_sync_prev <= 2'b00;
      r_wheel_l   <= 4'b0000;
      r_wheel_r   <= 4'b0000;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_div       <= w_div_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx_l     <= w_idx_l_nxt;
      r_idx_r     <= w_idx_r_nxt;
      r_turn_left <= w_turn_left_nxt;
      r_sync      <= {r_sync[SYNC_W-3:0], bump};
      r_sync_prev <= w_sync_out;
      r_wheel_l   <= (w_state_nxt == S_IDLE) ? 4'b0000 : f_coil(w_idx_l_nxt);
      r_wheel_r   <= (w_state_nxt == S_IDLE) ? 4'b0000 : f_coil(w_idx_r_nxt);
      r_busy      <= (w_state_nxt == S_BACKUP) || (w_state_nxt == S_TURN);
    end
  end

  assign wheel_wires_left  = r_wheel_l;
  assign wheel_wires_right = r_wheel_r;
  assign nav_state         = r_state;
  assign busy              = r_busy;

endmodule
`default_nettype wire

// File: doc/robot_nav_ctrl.md
Name: robot_nav_ctrl

Overview:
- Parametrised successor to the robot top-level drive logic.
- Drives two 4-wire unipolar stepper wheels (left, right) from a single navigation FSM.
- Reacts to a 2-channel bump sensor (left/right) with a back-up then turn-away manoeuvre, then resumes forward travel.
- Step rate, manoeuvre lengths and synchroniser depth are parametrised; sits directly under the robot top level, between sensor pins and wheel coil drivers.

Parameters:
STEP_DIV, 4, clock cycles per phase advance (>=2)
BACKUP_STEPS, 8, phase advances spent reversing after a bump (>=1)
TURN_STEPS, 4, phase advances spent pivoting after back-up (>=1)
SYNC_STAGES, 2, bump synchroniser flop count (>=2)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  reset, asynchronous, active-low (asserted when 0)
enable  input  1  run request; 0 forces IDLE
bump  input  2  bump sensors, [0]=left, [1]=right, asynchronous, active-high
wheel_wires_left  output  4  left motor coil drive, one-hot phase or 0000
wheel_wires_right  output  4  right motor coil drive, one-hot phase or 0000
nav_state  output  2  00 IDLE, 01 FWD, 10 BACKUP, 11 TURN
busy  output  1  1 while in BACKUP or TURN

Behaviour:
- Reset (rst=0, async): state IDLE, both phase indices 0, divider 0, step count 0, synchronisers 0. Outputs: wheels 0000, nav_state 00, busy 0.
- Coil drive: IDLE gives 0000 on both wheels. Otherwise each wheel outputs the one-hot of its phase index: idx0=0001, 1=0010, 2=0100, 3=1000. Outputs are registered.
- Step tick: divider counts 0..STEP_DIV-1 while not IDLE; tick when divider==STEP_DIV-1. Divider clears on every state transition, so the first advance in a new state occurs STEP_DIV cycles after entry.
- Phase update on tick, indices mod 4 with wrap 3<->0:
  - FWD: L+1, R-1 (right wheel mirror-mounted).
  - BACKUP: L-1, R+1.
  - TURN right: L+1, R+1.
  - TURN left: L-1, R-1.
- Phase indices persist across IDLE so the rotor position is not lost.
- Bump path: each bit passes through a SYNC_STAGES-flop synchroniser, then rising-edge detect. A hit is registered on edge SYNC_STAGES+1 after bump is set up.
- Transitions, priority top-down:
  - enable=0: any state -> IDLE next cycle; manoeuvre aborted, step count cleared.
  - IDLE & enable=1 -> FWD.
  - FWD & bump edge -> BACKUP. Latch turn_dir: edge on [0] only -> right; [1] only -> left; both in same cycle -> right.
  - BACKUP: step count increments on tick; after BACKUP_STEPS ticks -> TURN, count cleared.
  - TURN: after TURN_STEPS ticks -> FWD, count cleared.
- Bump edges arriving in IDLE, BACKUP or TURN are discarded, not queued. A level held high across re-entry to FWD does not retrigger; a new rising edge is required.
- Bump edge on the same cycle as the FWD tick: the phase advances, then BACKUP is entered.
- busy = (state==BACKUP)|(state==TURN), registered with the state.
- Step counter width: clog2(max(BACKUP_STEPS,TURN_STEPS)+1).

Optional Feature:
HALF_STEP_EN
- Defined: phase index is mod 8 with half-step sequence idx0..7 = 0001,0011,0010,0110,0100,1100,1000,1001. Direction rules unchanged. BACKUP_STEPS and TURN_STEPS still count phase advances, so each manoeuvre covers half the angle. Reset index 0 drives 0001.
- Undefined: 4-phase full-step one-hot as above.

Test Plan:
All scenarios use defaults (STEP_DIV=4, BACKUP_STEPS=8, TURN_STEPS=4).
- Reset and enable: rst=0 for 2 cycles, then rst=1 and enable=1 -> nav_state=01 next cycle; wheels L=0001 R=0001; after 4 cycles L=0010 R=1000; after 16 cycles back to L=0001 R=0001 (wrap).
- Left bump: bump=01 for 2 cycles in FWD -> nav_state=10 and busy=1 on 3rd edge; 8 ticks reversing (32 cycles); nav_state=11 for 16 cycles with L and R both advancing +1; then nav_state=01, busy=0.
- Simultaneous bump: bump=11 single pulse -> same sequence as left bump, TURN direction right. A right-only bump gives TURN with both indices -1.
- Ignored bumps: bump pulses during BACKUP and TURN -> no extra manoeuvre, timing unchanged; bump held high into FWD -> no retrigger.
- Abort: enable=0 mid-BACKUP -> IDLE next cycle, wheels 0000, busy=0; enable=1 -> FWD resumes from the retained phase indices.
- Async reset mid-TURN: rst=0 between clock edges -> outputs 0000/00/0 immediately, without a clock edge.
